// File: rtl/traffic_light_top.sv
// Single-road traffic light: GREEN->YELLOW->RED with a seconds countdown on two 7-seg digits.
// Optional build macro TL_LEADING_ZERO_BLANK_EN blanks the tens digit when it would be 0.
module traffic_light_top #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SCAN_DIV    = 100_000,
    parameter int GREEN_TIME  = 10,
    parameter int YELLOW_TIME = 3,
    parameter int RED_TIME    = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    output logic       CA,
    output logic       CB,
    output logic       CC,
    output logic       CD,
    output logic       CE,
    output logic       CF,
    output logic       CG,
    output logic       DP,
    output logic [7:0] AN,
    output logic       R_out,
    output logic       G_out,
    output logic       B_out
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'b00,
        S_YELLOW = 2'b01,
        S_RED    = 2'b10,
        S_BAD    = 2'b11
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [6:0] L_GREEN  = 7'(GREEN_TIME);
    localparam logic [6:0] L_YELLOW = 7'(YELLOW_TIME);
    localparam logic [6:0] L_RED    = 7'(RED_TIME);

    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_scan_cnt;
    logic          r_digit_sel;
    logic [1:0]    r_state;
    logic [6:0]    r_remain;

    logic          w_tick;
    logic          w_scan_wrap;
    logic [1:0]    w_next;
    logic [6:0]    w_next_time;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;

    assign w_tick      = (r_tick_cnt == TICK_MAX);
    assign w_scan_wrap = (r_scan_cnt == SCAN_MAX);

    always_comb begin
        w_next      = S_RED;
        w_next_time = L_RED;
        case (r_state)
            S_GREEN: begin
                w_next      = S_YELLOW;
                w_next_time = L_YELLOW;
            end
            S_YELLOW: begin
                w_next      = S_RED;
                w_next_time = L_RED;
            end
            S_RED: begin
                w_next      = S_GREEN;
                w_next_time = L_GREEN;
            end
            default: begin
                w_next      = S_RED;
                w_next_time = L_RED;
            end
        endcase
    end

    // Reset is active-high even though the pin is named _n.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_state     <= S_GREEN;
            r_remain    <= L_GREEN;
            r_tick_cnt  <= '0;
            r_scan_cnt  <= '0;
            r_digit_sel <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            if (w_scan_wrap) begin
                r_digit_sel <= ~r_digit_sel;
            end
            case (r_state)
                S_GREEN, S_YELLOW, S_RED: begin
                    if (w_tick) begin
                        if (r_remain > 7'd1) begin
                            r_remain <= r_remain - 7'd1;
                        end else begin
                            r_state  <= w_next;
                            r_remain <= w_next_time;
                        end
                    end
                end
                default: begin
                    r_state  <= S_RED;
                    r_remain <= L_RED;
                end
            endcase
        end
    end

    always_comb begin
        R_out = 1'b0;
        G_out = 1'b0;
        case (r_state)
            S_GREEN:  G_out = 1'b1;
            S_YELLOW: begin
                R_out = 1'b1;
                G_out = 1'b1;
            end
            S_RED:    R_out = 1'b1;
            default:  R_out = 1'b1;
        endcase
    end

    assign B_out = 1'b0;
    assign DP    = 1'b1;

    assign w_digit = r_digit_sel ? 4'(r_remain / 7'd10)
                                 : 4'(r_remain % 7'd10);

    always_comb begin
        case (w_digit)
            4'd0:    w_seg = 7'b0000001;
            4'd1:    w_seg = 7'b1001111;
            4'd2:    w_seg = 7'b0010010;
            4'd3:    w_seg = 7'b0000110;
            4'd4:    w_seg = 7'b1001100;
            4'd5:    w_seg = 7'b0100100;
            4'd6:    w_seg = 7'b0100000;
            4'd7:    w_seg = 7'b0001111;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0000100;
            default: w_seg = 7'b1111111;
        endcase
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = w_seg;

`ifdef TL_LEADING_ZERO_BLANK_EN
    assign AN = !r_digit_sel ? 8'hFE :
                (r_remain < 7'd10) ? 8'hFF : 8'hFD;
`else
    assign AN = r_digit_sel ? 8'hFD : 8'hFE;
`endif

endmodule

// File: tb/tb_traffic_light_top.sv
// Directed bench for traffic_light_top with TICK_DIV=4, SCAN_DIV=2, times 5/2/4.
module tb_traffic_light_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ca, cb, cc, cd, ce, cf, cg, dp;
    logic [7:0] an;
    logic       r_o, g_o, b_o;

    int n_run  = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    int         rem_tab [12] = '{5, 4, 3, 2, 1, 2, 1, 4, 3, 2, 1, 5};
    logic [1:0] st_tab  [12] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 0};
    logic [1:0] rg_tab  [12] = '{1, 1, 1, 1, 1, 3, 3, 2, 2, 2, 2, 1};

    traffic_light_top #(
        .TICK_DIV    (4),
        .SCAN_DIV    (2),
        .GREEN_TIME  (5),
        .YELLOW_TIME (2),
        .RED_TIME    (4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst),
        .CA        (ca),
        .CB        (cb),
        .CC        (cc),
        .CD        (cd),
        .CE        (ce),
        .CF        (cf),
        .CG        (cg),
        .DP        (dp),
        .AN        (an),
        .R_out     (r_o),
        .G_out     (g_o),
        .B_out     (b_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] segs();
        return {ca, cb, cc, cd, ce, cf, cg};
    endfunction

    initial begin
        logic [7:0] exp_an;
        int         k;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_state", 32'(dut.r_state), 32'd0);
        chk("rst_G", 32'(g_o), 32'd1);
        chk("rst_R", 32'(r_o), 32'd0);
        chk("rst_B", 32'(b_o), 32'd0);
        chk("rst_AN", 32'(an), 32'hFE);
        chk("rst_seg", 32'(segs()), 32'(7'b0100100));
        chk("rst_DP", 32'(dp), 32'd1);

        for (int c = 0; c <= 44; c++) begin
            k = c / 4;
            chk($sformatf("run_state_c%0d", c),
                32'(dut.r_state), 32'(st_tab[k]));
            chk($sformatf("run_remain_c%0d", c),
                32'(dut.r_remain), 32'(rem_tab[k]));
            chk($sformatf("run_RG_c%0d", c),
                32'({r_o, g_o}), 32'(rg_tab[k]));
            chk($sformatf("run_B_c%0d", c), 32'(b_o), 32'd0);
            if (((c / 2) % 2) == 0) begin
                chk($sformatf("run_AN_c%0d", c), 32'(an), 32'hFE);
                chk($sformatf("run_ones_c%0d", c),
                    32'(segs()), 32'(seg_tab[rem_tab[k]]));
            end else begin
`ifdef TL_LEADING_ZERO_BLANK_EN
                exp_an = 8'hFF;
                chk($sformatf("run_AN_c%0d", c), 32'(an), 32'(exp_an));
`else
                exp_an = 8'hFD;
                chk($sformatf("run_AN_c%0d", c), 32'(an), 32'(exp_an));
                chk($sformatf("run_tens_c%0d", c),
                    32'(segs()), 32'(7'b0000001));
`endif
            end
            @(negedge clk);
        end

        // Now at clock 45; yellow begins at 64, tick fires in clock 67.
        repeat (22) @(negedge clk);
        chk("y_RG", 32'({r_o, g_o}), 32'd3);
        chk("y_remain", 32'(dut.r_remain), 32'd2);
        chk("y_tick_cnt", 32'(dut.r_tick_cnt), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_state", 32'(dut.r_state), 32'd0);
        chk("mid_rst_remain", 32'(dut.r_remain), 32'd5);
        chk("mid_rst_tick", 32'(dut.r_tick_cnt), 32'd0);
        chk("mid_rst_AN", 32'(an), 32'hFE);
        chk("mid_rst_seg", 32'(segs()), 32'(7'b0100100));

        repeat (19) @(negedge clk);
        chk("pre_trans_state", 32'(dut.r_state), 32'd0);
        chk("pre_trans_remain", 32'(dut.r_remain), 32'd1);
        @(negedge clk);
        chk("trans_state", 32'(dut.r_state), 32'd1);
        chk("trans_remain", 32'(dut.r_remain), 32'd2);
        chk("trans_RG", 32'({r_o, g_o}), 32'd3);

        force dut.r_state = 2'b11;
        #1;
        release dut.r_state;
        #1;
        chk("bad_R", 32'(r_o), 32'd1);
        chk("bad_G", 32'(g_o), 32'd0);
        @(negedge clk);
        chk("bad_next_state", 32'(dut.r_state), 32'd2);
        chk("bad_next_remain", 32'(dut.r_remain), 32'd4);
        chk("bad_next_R", 32'(r_o), 32'd1);
        chk("bad_next_G", 32'(g_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
